// File: rtl/tdc_acq_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_acq_serializer_pkg
// Description : Shared constants, state encoding and width helper for the
//               TDC acquisition serializer (histogram-builder front end).
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_acq_serializer_pkg;

   // Timestamp width, pixel count and acquisitions per frame
   localparam int NP        = 10;
   localparam int PIXEL_NUM = 6;
   localparam int ACQ_NUM   = 4;

   // Emitted value for a pixel that saw no hit during the window
   localparam int NO_HIT    = 0;

   // clog2 that never returns a zero width, so single-entry counters stay legal
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PIX_CNT_W = clog2_min1(PIXEL_NUM);
   localparam int ACQ_IDX_W = clog2_min1(ACQ_NUM);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_EMIT    = 2'd2
   } state_t;

endpackage : tdc_acq_serializer_pkg
`default_nettype wire

// File: rtl/tdc_acq_serializer_pixel_hit_latch.sv
`default_nettype none
// ============================================================================
// Module      : tdc_acq_serializer_pixel_hit_latch
// Description : Per-pixel first-hit latch. Keeps the got flag and the first
//               timestamp seen while capture is enabled; a zero timestamp is
//               stored as 1 so that 0 can mean "no hit". o_word is the
//               look-ahead value (what the pixel will hold after this edge),
//               letting the emitter serialise a hit taken in the closing cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_acq_serializer_pixel_hit_latch #(
   parameter int NP = 10
) (
   input  logic          clk,
   input  logic          i_clr,
   input  logic          i_captureEn,
   input  logic          i_hitValid,
   input  logic [NP-1:0] i_hitData,
   output logic [NP-1:0] o_word
);
   import tdc_acq_serializer_pkg::*;

   logic          r_got;
   logic [NP-1:0] r_ts;

   logic          w_take;
   logic [NP-1:0] w_tsSub;
   logic          w_gotNext;
   logic [NP-1:0] w_tsNext;

   assign w_take  = i_captureEn & i_hitValid & ~r_got;
   assign w_tsSub = (i_hitData == '0) ? NP'(1) : i_hitData;

   // Next-state of the latch: clear wins, otherwise the first hit sticks
   always_comb begin
      w_gotNext = r_got;
      w_tsNext  = r_ts;
      if (i_clr) begin
         w_gotNext = 1'b0;
         w_tsNext  = '0;
      end else if (w_take) begin
         w_gotNext = 1'b1;
         w_tsNext  = w_tsSub;
      end
   end

   assign o_word = w_gotNext ? w_tsNext : NP'(NO_HIT);

   // Hold the got flag and captured timestamp
   always_ff @(posedge clk) begin
      r_got <= w_gotNext;
      r_ts  <= w_tsNext;
   end

endmodule : tdc_acq_serializer_pixel_hit_latch
`default_nettype wire

// File: rtl/tdc_acq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tdc_acq_serializer
// Description : Captures the first TDC timestamp per pixel during each
//               acquisition window, then streams one word per pixel in pixel
//               order on wrEn/data. Counts acquisitions per frame, pulses
//               frameDone with the last word of a frame, and keeps a sticky
//               protocol-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_acq_serializer #(
   parameter int NP        = tdc_acq_serializer_pkg::NP,
   parameter int PIXEL_NUM = tdc_acq_serializer_pkg::PIXEL_NUM,
   parameter int ACQ_NUM   = tdc_acq_serializer_pkg::ACQ_NUM
) (
   input  logic                    clk,
   input  logic                    res,
   input  logic                    acqStart,
   input  logic                    acqEnd,
   input  logic [PIXEL_NUM-1:0]    hitValid,
   input  logic [PIXEL_NUM*NP-1:0] hitData,
   output logic                    wrEn,
   output logic [NP-1:0]           data,
   output logic [tdc_acq_serializer_pkg::clog2_min1(ACQ_NUM)-1:0] acqIdx,
   output logic                    frameDone,
   output logic                    busy,
   output logic                    ovfErr
);
   import tdc_acq_serializer_pkg::*;

   localparam int C_PIX_W = clog2_min1(PIXEL_NUM);
   localparam int C_ACQ_W = clog2_min1(ACQ_NUM);
   localparam logic [C_PIX_W-1:0] C_PIX_LAST = C_PIX_W'(PIXEL_NUM - 1);
   localparam logic [C_ACQ_W-1:0] C_ACQ_LAST = C_ACQ_W'(ACQ_NUM - 1);

   state_t               r_state;
   logic [C_PIX_W-1:0]   r_pixCnt;
   logic [C_ACQ_W-1:0]   r_acqIdx;
   logic                 r_wrEn;
   logic [NP-1:0]        r_data;
   logic                 r_frameDone;
   logic                 r_busy;
   logic                 r_ovfErr;

   logic                 w_clr;
   logic                 w_captureEn;
   logic [C_PIX_W-1:0]   w_selIdx;
   logic [NP-1:0]        w_selWord;
   logic [NP-1:0]        w_word [PIXEL_NUM];

   // Latches are wiped on reset and whenever a new window opens
   assign w_clr       = res | ((r_state == S_IDLE) & acqStart);
   assign w_captureEn = (r_state == S_CAPTURE);

   generate
      for (genvar p = 0; p < PIXEL_NUM; p++) begin : g_pixel
         tdc_acq_serializer_pixel_hit_latch #(
            .NP (NP)
         ) u_latch (
            .clk         (clk),
            .i_clr       (w_clr),
            .i_captureEn (w_captureEn),
            .i_hitValid  (hitValid[p]),
            .i_hitData   (hitData[p*NP +: NP]),
            .o_word      (w_word[p])
         );
      end
   endgenerate

   // Pixel to present next: pixel 0 when the window closes, else the successor
   assign w_selIdx = (r_state == S_EMIT) ? r_pixCnt + 1'b1 : '0;

   // Output word mux; out-of-range index (only seen on the last word) gives 0
   always_comb begin
      w_selWord = '0;
      for (int p = 0; p < PIXEL_NUM; p++) begin
         if (w_selIdx == C_PIX_W'(p)) begin
            w_selWord = w_word[p];
         end
      end
   end

   // Control FSM with registered stream, index and status outputs
   always_ff @(posedge clk) begin
      if (res) begin
         r_state     <= S_IDLE;
         r_pixCnt    <= '0;
         r_acqIdx    <= '0;
         r_wrEn      <= 1'b0;
         r_data      <= '0;
         r_frameDone <= 1'b0;
         r_busy      <= 1'b0;
         r_ovfErr    <= 1'b0;
      end else begin
         r_frameDone <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (acqStart) begin
                  r_state <= S_CAPTURE;
                  r_busy  <= 1'b1;
               end
            end
            S_CAPTURE: begin
               if (acqStart) begin
                  r_ovfErr <= 1'b1;
               end
               if (acqEnd) begin
                  r_state     <= S_EMIT;
                  r_wrEn      <= 1'b1;
                  r_data      <= w_selWord;
                  r_pixCnt    <= '0;
                  r_frameDone <= (PIXEL_NUM == 1) && (r_acqIdx == C_ACQ_LAST);
               end
            end
            S_EMIT: begin
               if (acqStart) begin
                  r_ovfErr <= 1'b1;
               end
               if (r_pixCnt == C_PIX_LAST) begin
                  r_state  <= S_IDLE;
                  r_busy   <= 1'b0;
                  r_wrEn   <= 1'b0;
                  r_data   <= '0;
                  r_pixCnt <= '0;
                  r_acqIdx <= (r_acqIdx == C_ACQ_LAST) ? '0 : r_acqIdx + 1'b1;
               end else begin
                  r_pixCnt    <= r_pixCnt + 1'b1;
                  r_data      <= w_selWord;
                  r_frameDone <= (w_selIdx == C_PIX_LAST) && (r_acqIdx == C_ACQ_LAST);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_wrEn  <= 1'b0;
            end
         endcase
      end
   end

   assign wrEn      = r_wrEn;
   assign data      = r_data;
   assign acqIdx    = r_acqIdx;
   assign frameDone = r_frameDone;
   assign busy      = r_busy;
   assign ovfErr    = r_ovfErr;

endmodule : tdc_acq_serializer
`default_nettype wire

// File: tb/tb_tdc_acq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_acq_serializer
// Description : Self-checking bench for tdc_acq_serializer: a cycle table for
//               the capture rules, hand sequences for reset/protocol corners,
//               and randomized acquisitions against a first-hit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_acq_serializer;
   localparam int NP = 10;
   localparam int PIXEL_NUM = 6;
   localparam int ACQ_NUM = 4;
   localparam int HW = PIXEL_NUM * NP;

   logic                 clk = 1'b0;
   logic                 res = 1'b0;
   logic                 acqStart = 1'b0;
   logic                 acqEnd = 1'b0;
   logic [PIXEL_NUM-1:0] hitValid = '0;
   logic [HW-1:0]        hitData = '0;
   logic                 wrEn;
   logic [NP-1:0]        data;
   logic [1:0]           acqIdx;
   logic                 frameDone;
   logic                 busy;
   logic                 ovfErr;

   int n_checks = 0;
   int n_errors = 0;
   int m_idx = 0;
   bit m_ovf = 0;

   logic [PIXEL_NUM-1:0] cap_hv [0:15];
   logic [HW-1:0]        cap_hd [0:15];

   typedef struct {
      logic                 acqS;
      logic                 acqE;
      logic [PIXEL_NUM-1:0] hv;
      logic [HW-1:0]        hd;
      logic                 expWr;
      logic [NP-1:0]        expData;
      logic                 expBusy;
      logic [1:0]           expIdx;
      logic                 expFD;
   } vec_t;

   vec_t tbl [11];

   tdc_acq_serializer #(.NP(NP), .PIXEL_NUM(PIXEL_NUM), .ACQ_NUM(ACQ_NUM)) dut (
      .clk(clk), .res(res), .acqStart(acqStart), .acqEnd(acqEnd),
      .hitValid(hitValid), .hitData(hitData), .wrEn(wrEn), .data(data),
      .acqIdx(acqIdx), .frameDone(frameDone), .busy(busy), .ovfErr(ovfErr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [HW-1:0] pk(input int p, input int v);
      logic [HW-1:0] r;
      r = '0;
      r[p*NP +: NP] = NP'(v);
      return r;
   endfunction

   function automatic vec_t mkv(input logic s, input logic e, input logic [PIXEL_NUM-1:0] hv,
                                input logic [HW-1:0] hd, input logic wr, input int d,
                                input logic b, input int ix, input logic fd);
      vec_t v;
      v.acqS = s; v.acqE = e; v.hv = hv; v.hd = hd; v.expWr = wr;
      v.expData = NP'(d); v.expBusy = b; v.expIdx = 2'(ix); v.expFD = fd;
      return v;
   endfunction

   function automatic logic [HW-1:0] rand_hd();
      logic [HW-1:0] r;
      for (int p = 0; p < PIXEL_NUM; p++) begin
         r[p*NP +: NP] = ($urandom_range(0, 7) == 0) ? '0 : NP'($urandom_range(0, 1023));
      end
      return r;
   endfunction

   task automatic gen_rand(input int ncap);
      for (int c = 0; c <= ncap; c++) begin
         cap_hv[c] = PIXEL_NUM'($urandom_range(0, 63) & $urandom_range(0, 63));
         cap_hd[c] = rand_hd();
      end
   endtask

   task automatic do_reset();
      res = 1'b1;
      tick();
      tick();
      res = 1'b0;
      m_idx = 0;
      m_ovf = 0;
   endtask

   // One full acquisition: cap_*[0] is the acqStart cycle, 1..ncap are capture
   // cycles with acqEnd on ncap. Expected words = first hit per pixel, 0 -> 1.
   task automatic run_acq(input int ncap, input bit startInEmit, input bit startWithEnd);
      logic [NP-1:0] expw [PIXEL_NUM];
      bit found;
      for (int p = 0; p < PIXEL_NUM; p++) begin
         expw[p] = '0;
         found = 0;
         for (int c = 1; c <= ncap; c++) begin
            if (!found && cap_hv[c][p]) begin
               expw[p] = cap_hd[c][p*NP +: NP];
               if (expw[p] == 0) expw[p] = 1;
               found = 1;
            end
         end
      end
      acqStart = 1'b1; acqEnd = 1'b0;
      hitValid = cap_hv[0]; hitData = cap_hd[0];
      tick();
      acqStart = 1'b0;
      chk("acq.busy", 32'(busy), 1);
      chk("acq.wrEn_cap", 32'(wrEn), 0);
      for (int c = 1; c <= ncap; c++) begin
         hitValid = cap_hv[c]; hitData = cap_hd[c];
         acqEnd = (c == ncap);
         acqStart = startWithEnd && (c == ncap);
         tick();
         if (c < ncap) chk("acq.wrEn_cap", 32'(wrEn), 0);
      end
      acqEnd = 1'b0; acqStart = 1'b0;
      if (startInEmit || startWithEnd) m_ovf = 1;
      for (int w = 0; w < PIXEL_NUM; w++) begin
         chk($sformatf("emit.wrEn[%0d]", w), 32'(wrEn), 1);
         chk($sformatf("emit.data[%0d]", w), 32'(data), 32'(expw[w]));
         chk($sformatf("emit.acqIdx[%0d]", w), 32'(acqIdx), 32'(m_idx));
         chk($sformatf("emit.frameDone[%0d]", w), 32'(frameDone),
             32'((w == PIXEL_NUM-1) && (m_idx == ACQ_NUM-1)));
         hitValid = PIXEL_NUM'($urandom());
         hitData = rand_hd();
         acqStart = startInEmit && (w == 2);
         tick();
         acqStart = 1'b0;
      end
      hitValid = '0;
      m_idx = (m_idx + 1) % ACQ_NUM;
      chk("post.wrEn", 32'(wrEn), 0);
      chk("post.data", 32'(data), 0);
      chk("post.busy", 32'(busy), 0);
      chk("post.frameDone", 32'(frameDone), 0);
      chk("post.acqIdx", 32'(acqIdx), 32'(m_idx));
      chk("post.ovfErr", 32'(ovfErr), 32'(m_ovf));
   endtask

   initial begin
      // Cycle table: capture rules on acquisition 0 (first-hit, zero->1,
      // start-cycle hit ignored, end-cycle hit captured, emit-time hits ignored)
      tbl[0]  = mkv(1, 0, 6'b010000, pk(4, 555),                           0, 0,    1, 0, 0);
      tbl[1]  = mkv(0, 0, 6'b001011, pk(0, 108) | pk(1, 200) | pk(3, 0),   0, 0,    1, 0, 0);
      tbl[2]  = mkv(0, 0, 6'b000110, pk(1, 90) | pk(2, 511),               0, 0,    1, 0, 0);
      tbl[3]  = mkv(0, 0, 6'b100001, pk(5, 1022) | pk(0, 7),               0, 0,    1, 0, 0);
      tbl[4]  = mkv(0, 1, 6'b010000, pk(4, 300),                           1, 108,  1, 0, 0);
      tbl[5]  = mkv(0, 0, 6'b111111, '1,                                   1, 200,  1, 0, 0);
      tbl[6]  = mkv(0, 0, 6'b111111, '1,                                   1, 511,  1, 0, 0);
      tbl[7]  = mkv(0, 0, 6'b111111, '1,                                   1, 1,    1, 0, 0);
      tbl[8]  = mkv(0, 0, 6'b111111, '1,                                   1, 300,  1, 0, 0);
      tbl[9]  = mkv(0, 0, 6'b000000, '0,                                   1, 1022, 1, 0, 0);
      tbl[10] = mkv(0, 0, 6'b000000, '0,                                   0, 0,    0, 1, 0);

      // Reset with random inputs
      res = 1'b1;
      for (int i = 0; i < 2; i++) begin
         acqStart = 1'($urandom()); acqEnd = 1'($urandom());
         hitValid = PIXEL_NUM'($urandom()); hitData = rand_hd();
         tick();
      end
      chk("rst.wrEn", 32'(wrEn), 0);
      chk("rst.data", 32'(data), 0);
      chk("rst.acqIdx", 32'(acqIdx), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.ovfErr", 32'(ovfErr), 0);
      chk("rst.frameDone", 32'(frameDone), 0);
      res = 1'b0; acqStart = 1'b0; acqEnd = 1'b0; hitValid = '0;
      // Idle, including a stray acqEnd
      for (int i = 0; i < 3; i++) begin
         acqEnd = (i == 1);
         hitValid = PIXEL_NUM'($urandom());
         tick();
         chk("idle.wrEn", 32'(wrEn), 0);
         chk("idle.busy", 32'(busy), 0);
      end
      acqEnd = 1'b0; hitValid = '0;

      // Table-driven capture rules
      for (int i = 0; i < 11; i++) begin
         acqStart = tbl[i].acqS; acqEnd = tbl[i].acqE;
         hitValid = tbl[i].hv; hitData = tbl[i].hd;
         tick();
         chk($sformatf("tbl[%0d].wrEn", i), 32'(wrEn), 32'(tbl[i].expWr));
         chk($sformatf("tbl[%0d].data", i), 32'(data), 32'(tbl[i].expData));
         chk($sformatf("tbl[%0d].busy", i), 32'(busy), 32'(tbl[i].expBusy));
         chk($sformatf("tbl[%0d].acqIdx", i), 32'(acqIdx), 32'(tbl[i].expIdx));
         chk($sformatf("tbl[%0d].frameDone", i), 32'(frameDone), 32'(tbl[i].expFD));
      end
      acqStart = 1'b0; acqEnd = 1'b0; hitValid = '0;
      m_idx = 1;

      // Single acquisition: p0=108, p2=511, p5=1022
      for (int c = 0; c <= 4; c++) begin cap_hv[c] = '0; cap_hd[c] = '0; end
      cap_hv[1] = 6'b000001; cap_hd[1] = pk(0, 108);
      cap_hv[2] = 6'b000100; cap_hd[2] = pk(2, 511);
      cap_hv[3] = 6'b100000; cap_hd[3] = pk(5, 1022);
      run_acq(4, 0, 0);

      // Bring index to 0, then one full frame back-to-back
      for (int a = 0; a < 2; a++) begin gen_rand(3); run_acq(3, 0, 0); end
      chk("frame.startIdx", 32'(acqIdx), 0);
      for (int a = 0; a < ACQ_NUM; a++) begin
         int n;
         n = $urandom_range(1, 8);
         gen_rand(n);
         run_acq(n, 0, 0);
      end

      // Protocol errors: acqStart in EMIT, then sticky, then start+end together
      gen_rand(4); run_acq(4, 1, 0);
      gen_rand(2); run_acq(2, 0, 0);
      gen_rand(5); run_acq(5, 0, 0);
      gen_rand(3); run_acq(3, 0, 1);

      // Randomized acquisitions against the model
      for (int a = 0; a < 13; a++) begin
         int n;
         n = $urandom_range(1, 12);
         gen_rand(n);
         run_acq(n, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end

      // Reset in the middle of EMIT (after the third word)
      acqStart = 1'b1; tick(); acqStart = 1'b0;
      hitValid = '1; hitData = pk(0, 77) | pk(3, 99); acqEnd = 1'b1; tick();
      acqEnd = 1'b0; hitValid = '0;
      for (int w = 0; w < 3; w++) begin
         chk($sformatf("midrst.wrEn[%0d]", w), 32'(wrEn), 1);
         if (w < 2) tick();
      end
      chk("midrst.preOvf", 32'(ovfErr), 32'(m_ovf));
      res = 1'b1; tick(); res = 1'b0;
      m_idx = 0; m_ovf = 0;
      chk("midrst.wrEn", 32'(wrEn), 0);
      chk("midrst.data", 32'(data), 0);
      chk("midrst.acqIdx", 32'(acqIdx), 0);
      chk("midrst.ovfErr", 32'(ovfErr), 0);
      chk("midrst.busy", 32'(busy), 0);
      tick();
      chk("midrst.idleWrEn", 32'(wrEn), 0);
      // Following acquisition with no hits emits all zeros
      for (int c = 0; c <= 3; c++) begin cap_hv[c] = '0; cap_hd[c] = rand_hd(); end
      run_acq(3, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time guard so the run can never hang
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule : tb_tdc_acq_serializer
`default_nettype wire

// File: doc/tdc_acq_serializer.md
Name: tdc_acq_serializer

Overview:
- Upstream stage of the histogram builder FSM.
- Captures the first TDC timestamp per pixel during each acquisition window.
- After the window closes, emits one word per pixel in fixed pixel order on a wrEn/data stream, the exact format the histogram builder consumes.
- Pixels with no hit emit 0. The block counts acquisitions per frame and flags frame completion.

Parameters:
- NP, 10, timestamp width in bits (matches `Np).
- PIXEL_NUM, 6, pixels serviced; words emitted per acquisition.
- ACQ_NUM, 4, acquisitions per frame.

Ports:
- clk  in  1  single clock.
- res  in  1  reset; synchronous, active-high.
- acqStart  in  1  one-cycle pulse; opens an acquisition window.
- acqEnd  in  1  one-cycle pulse; closes the window.
- hitValid  in  PIXEL_NUM  per-pixel hit strobe.
- hitData  in  PIXEL_NUM*NP  packed timestamps; pixel p occupies [p*NP +: NP].
- wrEn  out  1  output word valid.
- data  out  NP  output timestamp; 0 means no hit.
- acqIdx  out  clog2(ACQ_NUM)  index of the acquisition being captured or emitted.
- frameDone  out  1  one-cycle pulse on the last word of the last acquisition.
- busy  out  1  high in CAPTURE and EMIT.
- ovfErr  out  1  sticky protocol-error flag.

Behaviour:
- Reset (sampled at the rising edge while res=1):
  - wrEn, data, acqIdx, frameDone, busy, ovfErr all 0.
  - All capture registers and got-flags cleared; pixel counter 0; state IDLE.
  - Reset overrides every other input, including mid-EMIT. wrEn is low in the cycle after res is sampled.
- States: IDLE, CAPTURE, EMIT. All outputs are registered.
- IDLE:
  - acqStart=1 → clear all got-flags, go to CAPTURE.
  - Hits in the acqStart cycle are ignored.
  - acqEnd in IDLE is ignored.
- CAPTURE, per pixel p each cycle:
  - If hitValid[p] and !got[p]: latch hitData[p], set got[p].
  - Later hits on the same pixel are ignored (first-hit-wins).
  - A valid hit with value 0 is stored as 1, because 0 is reserved for "no hit".
  - acqEnd=1 → go to EMIT. Hits in the acqEnd cycle are still captured.
  - acqStart in CAPTURE: ignored, sets ovfErr.
  - acqStart and acqEnd in the same cycle: acqEnd wins and ovfErr is set.
- EMIT:
  - Pixel counter runs 0..PIXEL_NUM-1, one word per cycle, no gaps.
  - data = got[p] ? ts[p] : 0; wrEn=1.
  - If acqEnd is sampled at edge N, wrEn is high in cycles N+1..N+PIXEL_NUM.
  - hitValid is ignored.
  - acqStart in EMIT: ignored, sets ovfErr.
  - After the last word: state → IDLE, wrEn → 0, data → 0 in the next cycle.
- acqIdx:
  - Increments when the last word of an acquisition is emitted.
  - If acqIdx == ACQ_NUM-1 at that point, it wraps to 0 and frameDone pulses high in the same cycle as that last word.
  - acqIdx is stable for the whole CAPTURE/EMIT of one acquisition.
- ovfErr: once set, stays 1 until res.
- busy = (state != IDLE), registered with the state.
- Width rules:
  - No arithmetic on timestamps beyond the 0→1 substitution.
  - Counters are sized clog2 of their bounds; the pixel counter never exceeds PIXEL_NUM-1.

Decomposition:
- Shared package (extends parametersSiFH):
  - NP, PIXEL_NUM, ACQ_NUM.
  - State enum {IDLE, CAPTURE, EMIT}.
  - Localparams for the counter widths.
  - The NO_HIT=0 constant.
- Sub-module pixel_hit_latch:
  - One per pixel, instantiated by generate.
  - Holds the got flag and the NP-bit timestamp.
  - Inputs: clr, captureEn, hitValid, hitData.
  - Implements first-hit-wins and 0→1 substitution.
- The top level holds the FSM, pixel counter, acqIdx, output mux and error logic.

Test Plan:
1. Reset: res=1 for 2 cycles with random inputs → wrEn=0, data=0, acqIdx=0, busy=0, ovfErr=0; release and stay idle → no wrEn.
2. Single acquisition: acqStart; hits p0=108, p2=511, p5=1022; acqEnd at edge N → wrEn high N+1..N+6, data=108,0,511,0,0,1022; acqIdx=0→1 after the 6th word.
3. Capture rules:
   - p1 hit 200 then 90 → emits 200.
   - p3 hit value 0 → emits 1.
   - p4 hit in the acqStart cycle → emits 0.
   - p4 hit in the acqEnd cycle with 300 → emits 300.
4. Frame: 4 back-to-back acquisitions → 24 words; frameDone high only with the 24th word; acqIdx sequence 0,1,2,3,0.
5. Protocol errors:
   - acqStart during EMIT → stream unaffected (6 words), state returns to IDLE, ovfErr=1 and stays 1 through 2 further acquisitions.
   - Simultaneous acqStart+acqEnd in CAPTURE → EMIT entered, ovfErr=1.
6. Reset mid-EMIT after the 3rd word → wrEn=0 next cycle, acqIdx=0, ovfErr=0; a subsequent acquisition with no hits emits 6 zeros.
